// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and types for the stopwatch input front end
package stopwatch_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int CLK_HZ                  = 100_000_000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    localparam int NUM_INPUTS = 4;
    localparam int IDX_PAUSE  = 0;
    localparam int IDX_RESET  = 1;
    localparam int IDX_ADJ    = 2;
    localparam int IDX_SEL    = 3;

    typedef enum logic {
        RUN_RUNNING = 1'b0,
        RUN_PAUSED  = 1'b1
    } run_state_e;

    // Reset press wins over a pause press landing on the same edge.
    function automatic run_state_e next_run_state(input run_state_e cur,
                                                  input logic       pause_rise,
                                                  input logic       reset_rise);
        run_state_e nxt;
        nxt = cur;
        if (reset_rise) begin
            nxt = RUN_RUNNING;
        end else if (pause_rise) begin
            nxt = (cur == RUN_PAUSED) ? RUN_RUNNING : RUN_PAUSED;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - 2-flop synchronizer plus counting debouncer for one raw input
module input_debouncer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Any return to the accepted value drops all progress toward a change.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// rtl/stopwatch_input_ctrl.sv - debounced button/switch front end producing pulses, pause state and levels
module stopwatch_input_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic paused,
    output logic pause_pulse,
    output logic reset_pulse,
    output logic adj,
    output logic sel
);

    logic [NUM_INPUTS-1:0] raw_w;
    logic [NUM_INPUTS-1:0] stable_w;

    assign raw_w[IDX_PAUSE] = btn_pause;
    assign raw_w[IDX_RESET] = btn_reset;
    assign raw_w[IDX_ADJ]   = sw_adj;
    assign raw_w[IDX_SEL]   = sw_sel;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (raw_w[g]),
            .stable_o (stable_w[g])
        );
    end

    logic       pause_prev_q, reset_prev_q;
    logic       pause_rise, reset_rise;
    logic       pause_pulse_q, reset_pulse_q;
    run_state_e state_q, state_d;

    // Previous accepted button levels; a rise is only counted once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_prev_q  <= 1'b0;
            reset_prev_q  <= 1'b0;
            pause_pulse_q <= 1'b0;
            reset_pulse_q <= 1'b0;
        end else begin
            pause_prev_q  <= stable_w[IDX_PAUSE];
            reset_prev_q  <= stable_w[IDX_RESET];
            pause_pulse_q <= pause_rise;
            reset_pulse_q <= reset_rise;
        end
    end

    assign pause_rise = stable_w[IDX_PAUSE] & ~pause_prev_q;
    assign reset_rise = stable_w[IDX_RESET] & ~reset_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN_RUNNING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = next_run_state(state_q, pause_rise, reset_rise);
    end

    always_comb begin
        paused = (state_q == RUN_PAUSED);
    end

    assign pause_pulse = pause_pulse_q;
    assign reset_pulse = reset_pulse_q;
    assign adj         = stable_w[IDX_ADJ];
    assign sel         = stable_w[IDX_SEL];

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// tb/tb_stopwatch_input_ctrl.sv - directed self-checking bench for stopwatch_input_ctrl
module tb_stopwatch_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_pause, btn_reset, sw_adj, sw_sel;
    logic paused, pause_pulse, reset_pulse, adj, sel;

    int n_checks = 0;
    int n_pass   = 0;
    int pc       = 0;
    int rc       = 0;
    int sel_bad  = 0;

    always #5 clk = ~clk;

    stopwatch_input_ctrl #(
        .DEBOUNCE_CYCLES (stopwatch_pkg::DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_pause   (btn_pause),
        .btn_reset   (btn_reset),
        .sw_adj      (sw_adj),
        .sw_sel      (sw_sel),
        .paused      (paused),
        .pause_pulse (pause_pulse),
        .reset_pulse (reset_pulse),
        .adj         (adj),
        .sel         (sel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each one and tallying pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pause_pulse) pc++;
            if (reset_pulse) rc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int pc0, rc0;
        rst = 1'b1;
        btn_pause = 1'b1; btn_reset = 1'b1; sw_adj = 1'b1; sw_sel = 1'b1;

        // Reset with every raw input high
        tick(1);
        check("rst_paused", paused, 0);
        check("rst_ppulse", pause_pulse, 0);
        check("rst_rpulse", reset_pulse, 0);
        check("rst_adj", adj, 0);
        check("rst_sel", sel, 0);
        tick(1);
        rst = 1'b0;
        pc = 0; rc = 0;
        tick(5);
        check("rst_adj_e4", {adj, sel}, 2'b00);
        tick(1);
        check("rst_adj_e5", {adj, sel}, 2'b11);
        check("rst_pp_e5", pause_pulse, 0);
        tick(1);
        check("rst_pulses_e6", {pause_pulse, reset_pulse}, 2'b11);
        check("rst_paused_e6", paused, 0);
        tick(1);
        check("rst_pulses_e7", {pause_pulse, reset_pulse}, 2'b00);
        btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        tick(10);
        check("rst_pcount", pc, 1);
        check("rst_rcount", rc, 1);
        check("adj_release", adj, 0);

        // Clean press, release, press again
        do_reset();
        pc = 0; rc = 0;
        btn_pause = 1'b1;
        tick(6);
        check("press_pp_e5", pause_pulse, 0);
        tick(1);
        check("press_pp_e6", pause_pulse, 1);
        check("press_paused", paused, 1);
        tick(1);
        check("press_pp_e7", pause_pulse, 0);
        tick(2);
        btn_pause = 1'b0;
        tick(10);
        check("press_hold_count", pc, 1);
        check("press_paused_hold", paused, 1);
        btn_pause = 1'b1;
        tick(10);
        btn_pause = 1'b0;
        tick(10);
        check("press2_paused", paused, 0);
        check("press2_count", pc, 2);

        // Glitch rejection on btn_reset
        rc = 0;
        btn_reset = 1'b1;
        tick(3);
        btn_reset = 1'b0;
        tick(10);
        check("glitch3_count", rc, 0);
        btn_reset = 1'b1;
        tick(4);
        btn_reset = 1'b0;
        tick(10);
        check("glitch4_count", rc, 1);

        // Bounce on sw_sel then settle high
        for (int ph = 0; ph < 10; ph++) begin
            sw_sel = (ph % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 2; k++) begin
                tick(1);
                if (sel !== 1'b0) sel_bad++;
            end
        end
        check("bounce_sel_low", sel_bad, 0);
        sw_sel = 1'b1;
        tick(5);
        check("bounce_sel_e4", sel, 0);
        tick(1);
        check("bounce_sel_e5", sel, 1);

        // Simultaneous pause and reset press while paused
        btn_pause = 1'b1;
        tick(10);
        btn_pause = 1'b0;
        tick(10);
        check("prio_setup_paused", paused, 1);
        btn_pause = 1'b1; btn_reset = 1'b1;
        tick(7);
        check("prio_pulses", {pause_pulse, reset_pulse}, 2'b11);
        check("prio_paused", paused, 0);
        btn_pause = 1'b0; btn_reset = 1'b0;
        tick(10);
        check("prio_paused_after", paused, 0);

        // Reset in the middle of a debounce
        do_reset();
        pc0 = pc; rc0 = rc;
        btn_pause = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("mid_no_pulse", pc - pc0, 0);
        tick(6);
        check("mid_pp_e5", pause_pulse, 0);
        tick(1);
        check("mid_pp_e6", pause_pulse, 1);
        check("mid_paused", paused, 1);
        btn_pause = 1'b0;
        tick(10);
        check("mid_count", pc - pc0, 1);
        check("mid_rcount", rc - rc0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_ctrl.md
# stopwatch_input_ctrl

User-input front end for the stopwatch. It synchronizes and debounces the raw board buttons and switches, then turns them into clean control signals for the time-keeping and display logic:
- one-cycle action pulses
- a pause/run toggle state
- stable adjust/select levels

It is the input-side counterpart to the seven-segment display driver and runs on the 100 MHz board clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive cycles an input must differ from its accepted value before the change is accepted (10 ms at 100 MHz); must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  board clock, 100 MHz; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- btn_reset  in  1  raw reset button, asynchronous, active-high.
- sw_adj  in  1  raw adjust switch, asynchronous.
- sw_sel  in  1  raw select switch (0 = minutes, 1 = seconds), asynchronous.
- paused  out  1  registered; 1 = stopwatch frozen.
- pause_pulse  out  1  registered; one-cycle strobe on each accepted pause press.
- reset_pulse  out  1  registered; one-cycle strobe on each accepted reset press.
- adj  out  1  registered debounced level of sw_adj.
- sel  out  1  registered debounced level of sw_sel.

## Operation
- Each of the 4 inputs gets its own synchronizer and debouncer.
  - Synchronizer: 2-flop chain, s1 then s2.
  - Debouncer: accepted value `stable` plus a counter `cnt`.
- Debouncer update, each edge:
  - If s2 == stable: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable ← s2, cnt ← 0.
  - Else: cnt ← cnt+1.
- Any return to the accepted value before the count completes clears cnt. There is no partial credit.
- Button debouncers also register stable_d. A rising edge is stable & ~stable_d. Releases produce no pulse.
- pause_pulse ← rise(pause); reset_pulse ← rise(reset).
- paused next-state:
  - rise(reset): paused ← 0. This has priority, including a pause press on the same edge.
  - Else rise(pause): paused ← ~paused.
  - Else: paused holds.
- adj and sel equal the stable value of their debouncer; no pulse is generated for switches.
- Reset (rst = 1 at an edge) clears every s1, s2, stable, stable_d, cnt and output to 0.
  - An in-progress debounce is discarded.
  - A button still held when rst deasserts is treated as a new press: a pulse follows after the full latency.
- Counter arithmetic: unsigned CNT_W bits. cnt never exceeds DEBOUNCE_CYCLES-1, so it never wraps.

## Timing
- Let edge 0 be the first edge that samples a changed raw input, which is then held. Let D = DEBOUNCE_CYCLES.
  - s1 changes at edge 0 and s2 at edge 1.
  - cnt reaches D-1 at edge D.
  - stable, and therefore adj/sel, updates at edge D+1.
  - pause_pulse, reset_pulse and the paused toggle update at edge D+2.
- Minimum accepted pulse width is D sampling edges. A raw level held for D-1 edges or fewer is rejected.
- Each pulse is high for exactly one clock cycle per accepted press, regardless of how long the button is held.
- Reset values:
  - paused = 0, pause_pulse = 0, reset_pulse = 0, adj = 0, sel = 0.
  - Outputs are valid on the cycle after the rst edge.

## Structure
- Shared package stopwatch_pkg holds:
  - DEBOUNCE_CYCLES_DEFAULT (1_000_000).
  - CLK_HZ (100_000_000).
  - Simulation override value DEBOUNCE_CYCLES_SIM = 4.
- One sub-module, input_debouncer, instantiated 4 times.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Contents: synchronizer, counter, `stable` output.
- Edge detection and the paused register live in stopwatch_input_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold rst for 2 cycles with all raw inputs at 1 → during reset all outputs are 0; after rst drops, pause_pulse and reset_pulse each fire once 6 edges later and adj = sel = 1 at edge 5.
- Clean press: btn_pause high from edge 0 for 10 cycles → pause_pulse is high only for the cycle after edge 6 and paused = 1; release and press again → paused = 0, with exactly 2 pulses in total.
- Glitch rejection: btn_reset high for 3 sampling edges → no reset_pulse ever; btn_reset high for 4 sampling edges → exactly one reset_pulse.
- Bounce: sw_sel toggles every 2 cycles for 20 cycles, then settles at 1 at edge T → sel stays 0 throughout the bounce and becomes 1 at edge T+5.
- Priority: with paused = 1, press btn_pause and btn_reset on the same edge → both pulses fire on the same cycle and paused = 0.
- Mid-debounce reset: assert rst while cnt = 2 with btn_pause held → no pulse from the aborted debounce; a new pause_pulse fires 6 edges after rst deasserts and paused = 1.
